// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_ctrl_pkg : opcode / ALU-class constants and the ID decode bundle
// Revision    : 1.0
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_IMM = 2'b10;
    localparam logic [1:0] ALU_R   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_control;
        logic       alu_2_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctrl_decode : combinational RV32I opcode -> control bundle
// Revision    : 1.0
// ---------------------------------------------------------------------------
module ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JUMP = 1'b0
) (
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_R: begin
                ctrl_o.alu_control = ALU_R;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
                ctrl_o.uses_rs2    = 1'b1;
            end
            OP_IMM: begin
                ctrl_o.alu_control = ALU_IMM;
                ctrl_o.alu_2_src   = 1'b1;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.alu_control = ALU_ADD;
                ctrl_o.alu_2_src   = 1'b1;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.mem_read    = 1'b1;
                ctrl_o.mem_to_reg  = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.alu_control = ALU_ADD;
                ctrl_o.alu_2_src   = 1'b1;
                ctrl_o.mem_write   = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
                ctrl_o.uses_rs2    = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o.alu_control = ALU_BR;
                ctrl_o.is_branch   = 1'b1;
                ctrl_o.uses_rs1    = 1'b1;
                ctrl_o.uses_rs2    = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                if (ENABLE_JUMP) begin
                    ctrl_o.alu_control = ALU_ADD;
                    ctrl_o.alu_2_src   = 1'b1;
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.is_jump     = 1'b1;
                    ctrl_o.uses_rs1    = (opcode_i == OP_JALR);
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_control : ID decode carried through ID/EX, EX/MEM, MEM/WB with hazards
// Revision     : 1.0
// ---------------------------------------------------------------------------
module pipe_control
    import rv_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter bit ENABLE_JUMP = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [1:0]        alu_control_o,
    output logic              alu_2_src_o,
    output logic              is_branch_o,
    output logic              is_jump_o,
    output logic              illegal_o,
    output logic [REG_AW-1:0] rd_ex_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [REG_AW-1:0] rd_mem_o,
    output logic              reg_write_mem_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [REG_AW-1:0] rd_wb_o
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_control;
        logic              alu_2_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              is_branch;
        logic              is_jump;
        logic              illegal;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } mem_wb_t;

    ctrl_bundle_t dec;
    logic         load_use;
    id_ex_t       id_ex_d,  id_ex_q;
    ex_mem_t      ex_mem_d, ex_mem_q;
    mem_wb_t      mem_wb_d, mem_wb_q;

    ctrl_decode #(
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (dec)
    );

    // x0 is never a real producer, so a load into rd=0 cannot cause a stall
    always_comb begin
        load_use = 1'b0;
        if (id_valid_i && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0)) begin
            load_use = (dec.uses_rs1 && (rs1_i == id_ex_q.rd)) ||
                       (dec.uses_rs2 && (rs2_i == id_ex_q.rd));
        end
    end

    assign stall_o = load_use && !hold_i && !flush_i;

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (!hold_i) begin
            mem_wb_d.valid      = ex_mem_q.valid;
            mem_wb_d.reg_write  = ex_mem_q.reg_write;
            mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
            mem_wb_d.rd         = ex_mem_q.rd;

            ex_mem_d.valid      = id_ex_q.valid;
            ex_mem_d.reg_write  = id_ex_q.reg_write;
            ex_mem_d.mem_read   = id_ex_q.mem_read;
            ex_mem_d.mem_write  = id_ex_q.mem_write;
            ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
            ex_mem_d.rd         = id_ex_q.rd;

            id_ex_d = '0;
            if (id_valid_i && !flush_i && !stall_o) begin
                id_ex_d.valid       = 1'b1;
                id_ex_d.alu_control = dec.alu_control;
                id_ex_d.alu_2_src   = dec.alu_2_src;
                id_ex_d.reg_write   = dec.reg_write && (rd_i != '0);
                id_ex_d.mem_read    = dec.mem_read;
                id_ex_d.mem_write   = dec.mem_write;
                id_ex_d.mem_to_reg  = dec.mem_to_reg;
                id_ex_d.is_branch   = dec.is_branch;
                id_ex_d.is_jump     = dec.is_jump;
                id_ex_d.illegal     = dec.illegal;
                id_ex_d.rd          = rd_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ex_valid_o      = id_ex_q.valid;
    assign alu_control_o   = id_ex_q.valid ? id_ex_q.alu_control : 2'b00;
    assign alu_2_src_o     = id_ex_q.valid & id_ex_q.alu_2_src;
    assign is_branch_o     = id_ex_q.valid & id_ex_q.is_branch;
    assign is_jump_o       = id_ex_q.valid & id_ex_q.is_jump;
    assign illegal_o       = id_ex_q.valid & id_ex_q.illegal;
    assign rd_ex_o         = {REG_AW{id_ex_q.valid}} & id_ex_q.rd;

    assign mem_read_o      = ex_mem_q.valid & ex_mem_q.mem_read;
    assign mem_write_o     = ex_mem_q.valid & ex_mem_q.mem_write;
    assign rd_mem_o        = {REG_AW{ex_mem_q.valid}} & ex_mem_q.rd;
    assign reg_write_mem_o = ex_mem_q.valid & ex_mem_q.reg_write;

    assign reg_write_o     = mem_wb_q.valid & mem_wb_q.reg_write;
    assign mem_to_reg_o    = mem_wb_q.valid & mem_wb_q.mem_to_reg;
    assign rd_wb_o         = {REG_AW{mem_wb_q.valid}} & mem_wb_q.rd;

endmodule
`default_nettype wire

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined main control unit for the 5-stage RV32I core.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and applies stall, flush and hold.
- Supersedes the single-cycle combinational control decoder. Adds load/store/jump decoding, illegal-opcode flagging and hazard handling.

Parameters:
- REG_AW, 5, register-index width.
- ENABLE_JUMP, 0, when 1, decodes JAL (1101111) and JALR (1100111); when 0, both are illegal.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- hold_i  input  1  global freeze (memory wait); all stage registers keep their value
- flush_i  input  1  taken branch/jump resolved in EX; squash the ID instruction
- id_valid_i  input  1  the ID stage holds a real instruction
- opcode_i  input  7  instruction[6:0] in ID
- rs1_i  input  REG_AW  instruction[19:15]
- rs2_i  input  REG_AW  instruction[24:20]
- rd_i  input  REG_AW  instruction[11:7]
- stall_o  output  1  load-use stall; upstream holds PC and IF/ID
- ex_valid_o  output  1  EX-stage valid
- alu_control_o  output  2  EX ALU op class
- alu_2_src_o  output  1  EX, 1 = immediate operand
- is_branch_o  output  1  EX conditional branch
- is_jump_o  output  1  EX JAL/JALR (0 if ENABLE_JUMP=0)
- illegal_o  output  1  EX instruction had an unknown opcode
- rd_ex_o  output  REG_AW  EX destination register
- mem_read_o  output  1  MEM-stage load
- mem_write_o  output  1  MEM-stage store
- rd_mem_o  output  REG_AW  MEM destination register
- reg_write_mem_o  output  1  MEM write-enable (for forwarding)
- reg_write_o  output  1  WB write-enable
- mem_to_reg_o  output  1  WB selects load data
- rd_wb_o  output  REG_AW  WB destination register

Behaviour:
- Decode is combinational in ID. Fields are alu_control / alu_2_src / reg_write / mem_read / mem_write / mem_to_reg / is_branch / is_jump / uses_rs1 / uses_rs2.
- 0110011 R-type: 11/0/1/0/0/0/0/0, uses rs1, rs2.
- 0010011 I-ALU: 10/1/1/0/0/0/0/0, uses rs1.
- 0000011 load: 00/1/1/1/0/1/0/0, uses rs1.
- 0100011 store: 00/1/0/0/1/0/0/0, uses rs1, rs2.
- 1100011 branch: 01/0/0/0/0/0/1/0, uses rs1, rs2.
- JAL (ENABLE_JUMP=1): 00/1/1/0/0/0/0/1, uses neither register.
- JALR (ENABLE_JUMP=1): 00/1/1/0/0/0/0/1, uses rs1.
- Any other opcode: all fields 0, illegal=1, uses neither register.
- rd==0 forces reg_write=0.
- Load-use stall: stall_o = id_valid_i & ex_valid_o & mem_read_ex & rd_ex_o!=0 & ((uses_rs1 & rs1_i==rd_ex_o) | (uses_rs2 & rs2_i==rd_ex_o)). stall_o is combinational.
- stall_o is also forced 0 while hold_i=1 or flush_i=1.
- Priority at each clock edge: hold_i > flush_i > stall_o > normal.
- hold_i=1: every stage register keeps its value.
- flush_i=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- stall_o=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
- Normal: ID/EX loads the decoded bundle with valid=id_valid_i; EX/MEM takes ID/EX; MEM/WB takes EX/MEM.
- A bubble is valid=0 with all control bits 0 and rd=0.
- Every stage output is gated by that stage's valid bit: an invalid stage drives all control outputs 0.
- Latency: ID decode appears on the EX outputs 1 cycle later, MEM outputs 2 cycles later, WB outputs 3 cycles later.
- Reset (rst_i=0, asynchronous): all stage registers clear to bubble. Every output is 0, including stall_o, since ex_valid_o=0.
- Deasserting reset mid-program restarts from the bubble state; no partial state survives.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR);
  - ALU class constants (ALU_ADD=00, ALU_BR=01, ALU_IMM=10, ALU_R=11);
  - a ctrl_bundle_t struct with the decode fields.
- One sub-module, ctrl_decode: purely combinational opcode -> ctrl_bundle_t, parameterised by ENABLE_JUMP.
- The pipeline registers and hazard logic live in pipe_control.

Test Plan:
- Reset: hold rst_i=0 with id_valid_i=1 and a toggling opcode -> every output 0, including stall_o. Release reset; ADD (0110011, rd=5) issued -> cycle+1 alu_control_o=11, alu_2_src_o=0; cycle+3 reg_write_o=1, rd_wb_o=5.
- Load-use: LW rd=3, then ADD rs1=3 -> stall_o=1 for exactly 1 cycle and ex_valid_o=0 the next cycle. ADD reaches EX one cycle late; LW shows mem_read_o=1, rd_mem_o=3.
- No false stall: LW rd=0, then ADD rs1=0 -> stall_o=0. LW rd=3, then I-ALU with rs2 field=3 (rs2 unused) -> stall_o=0.
- Flush with simultaneous stall: load-use condition plus flush_i=1 -> stall_o=0, ID/EX bubble, and the preceding load still advances to MEM.
- Hold: hold_i=1 for 3 cycles mid-stream -> all outputs frozen. After release, sequence continues with no instruction lost or duplicated.
- Opcodes: JAL (1101111) with ENABLE_JUMP=0 -> illegal_o=1, reg_write_o=0 at WB. With ENABLE_JUMP=1 -> is_jump_o=1, alu_2_src_o=1, reg_write_o=1. STORE -> mem_write_o=1, reg_write_o=0.
